// File: rtl/taylor_axil_slave_if.sv
// AXI4-Lite bus bundle between a master and the Taylor register block.
// Valid/ready rule on every channel: a transfer happens on the rising edge
// where VALID and READY are both high; once raised, VALID and its payload
// stay stable until that edge.
interface taylor_axil_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/taylor_axil_slave.sv
// AXI4-Lite register block for the Taylor core: CTRL/ARG/RESULT/STATUS.
// Turns a CTRL write into a one-cycle core_start pulse and captures the
// core's result on core_done.
module taylor_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  taylor_axil_slave_if.slave            s_axi,
  output logic                          core_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0] core_arg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] core_result,
  input  logic                          core_done
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ARG    = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          awready_q, awready_d, wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] arg_q, arg_d, result_q, result_d;
  logic          busy_q, busy_d, done_q, done_d, start_q, start_d;

  logic          aw_hs, w_hs, ar_hs, commit, start_req, done_clr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic [3:0]    c_strb;
  logic [1:0]    c_sel;
  logic          unused_ok;

  assign aw_hs  = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs   = s_axi.S_AXI_WVALID  & wready_q;
  assign ar_hs  = s_axi.S_AXI_ARVALID & arready_q;
  // A write commits as soon as both halves are either held or arriving now.
  assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign c_addr = aw_held_q ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign c_data = w_held_q  ? wdata_q  : s_axi.S_AXI_WDATA;
  assign c_strb = w_held_q  ? wstrb_q  : s_axi.S_AXI_WSTRB;
  assign c_sel  = c_addr[3:2];

  assign start_req = commit && (c_sel == REG_CTRL) && c_strb[0] && c_data[0] && !busy_q;
  assign done_clr  = commit && (c_sel == REG_STATUS) && c_strb[0] && c_data[1];

  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, c_addr[1:0],
                       s_axi.S_AXI_ARADDR[1:0]};

  // Write channel holding registers, B response and registered readies.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi.S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end
    if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (c_sel == REG_RESULT) ? RESP_SLVERR : RESP_OKAY;
    end
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d  && !bvalid_d;
  end

  // Register file updates: ARG strobes, start/busy, sticky done, RESULT capture.
  always_comb begin
    arg_d    = arg_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    start_d  = start_req;
    if (commit && (c_sel == REG_ARG)) begin
      for (int b = 0; b < 4; b++) begin
        if (c_strb[b]) arg_d[8*b +: 8] = c_data[8*b +: 8];
      end
    end
    if (done_clr || start_req) done_d = 1'b0;
    if (core_done) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      result_d = core_result;
    end
    // A start committing alongside a stale done pulse still marks the core busy.
    if (start_req) busy_d = 1'b1;
  end

  // Read channel: sample the pre-edge register state on the AR handshake.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (s_axi.S_AXI_ARADDR[3:2])
        REG_ARG:    rdata_d = arg_q;
        REG_RESULT: rdata_d = result_q;
        REG_STATUS: rdata_d = {{(DW-2){1'b0}}, done_q, busy_q};
        default:    rdata_d = '0;
      endcase
    end
    arready_d = !rvalid_d;
  end

  // State registers; reset drops every valid, hold and register at once.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      arg_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      arg_q     <= arg_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;
  assign core_start          = start_q;
  assign core_arg            = arg_q;
endmodule

// File: tb/tb_taylor_axil_slave.sv
// Directed testbench for taylor_axil_slave: register map, start/done flow,
// channel skew, backpressure and same-cycle collisions.
module tb_taylor_axil_slave;
  logic        clk;
  logic        rst_n;
  logic        core_start;
  logic [31:0] core_arg;
  logic [31:0] core_result;
  logic        core_done;

  int n_total = 0;
  int n_bad   = 0;
  int start_cnt = 0;

  taylor_axil_slave_if axi ();

  taylor_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .core_start    (core_start),
    .core_arg      (core_arg),
    .core_result   (core_result),
    .core_done     (core_done)
  );

  // Clock and start-pulse monitor (cycles with core_start high).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drivers assume they are entered at a falling edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_ok, w_ok;
    int n;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_WVALID  = 1'b1;
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) aw_ok = 1'b1;
      if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) w_ok = 1'b1;
      @(negedge clk);
      if (aw_ok) axi.S_AXI_AWVALID = 1'b0;
      if (w_ok) axi.S_AXI_WVALID = 1'b0;
      n++;
    end
    chk("wr_accept", {30'd0, aw_ok, w_ok}, 32'd3);
    n = 0;
    while (!axi.S_AXI_BVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
    resp = axi.S_AXI_BRESP;
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic ok;
    int n;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      ok = axi.S_AXI_ARREADY;
      @(negedge clk);
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!axi.S_AXI_RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd1);
    chk("rd_rresp", {30'd0, axi.S_AXI_RRESP}, 32'd0);
    data = axi.S_AXI_RDATA;
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic pulse_done(input logic [31:0] res);
    core_result = res;
    core_done   = 1'b1;
    @(negedge clk);
    core_done   = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          cnt0;

    rst_n = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    axi.S_AXI_AWADDR = '0;  axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;   axi.S_AXI_WSTRB = '0;  axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0;  axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;

    // Reset: 200 ns low, all handshake outputs quiet.
    repeat (10) @(negedge clk);
    chk("rst_outs", {26'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY,
                     axi.S_AXI_BVALID, axi.S_AXI_RVALID, core_start}, 32'd0);
    chk("rst_arg", core_arg, 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd7);
    axi_read(4'h4, rd); chk("rst_rd_arg", rd, 32'd0);
    axi_read(4'h8, rd); chk("rst_rd_result", rd, 32'd0);
    axi_read(4'hC, rd); chk("rst_rd_status", rd, 32'd0);

    // ARG byte strobes.
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, resp); chk("arg_full_resp", {30'd0, resp}, 32'd0);
    axi_write(4'h4, 32'h00001234, 4'h3, resp); chk("arg_half_resp", {30'd0, resp}, 32'd0);
    axi_read(4'h4, rd); chk("arg_strobe", rd, 32'hDEAD1234);
    chk("core_arg", core_arg, 32'hDEAD1234);

    // Start and complete.
    axi_write(4'h0, 32'h1, 4'hF, resp);
    repeat (3) @(negedge clk);
    chk("start_pulse", start_cnt, 32'd1);
    axi_read(4'hC, rd); chk("status_busy", rd, 32'h1);
    pulse_done(32'h3F800000);
    axi_read(4'hC, rd); chk("status_done", rd, 32'h2);
    axi_read(4'h8, rd); chk("result_load", rd, 32'h3F800000);
    axi_write(4'hC, 32'h2, 4'hF, resp);
    axi_read(4'hC, rd); chk("status_w1c", rd, 32'h0);

    // Start while busy is ignored.
    axi_write(4'h0, 32'h1, 4'hF, resp);
    repeat (2) @(negedge clk);
    cnt0 = start_cnt;
    chk("start2_pulse", cnt0, 32'd2);
    axi_write(4'h0, 32'h1, 4'hF, resp);
    chk("busy_start_resp", {30'd0, resp}, 32'd0);
    repeat (3) @(negedge clk);
    chk("busy_no_pulse", start_cnt, cnt0);
    axi_read(4'hC, rd); chk("busy_stays", rd, 32'h1);
    pulse_done(32'h40000000);
    axi_read(4'hC, rd); chk("status_done2", rd, 32'h2);

    // Skew: W three cycles ahead of AW, then B held off for 4 cycles.
    chk("w_rdy_idle", {31'd0, axi.S_AXI_WREADY}, 32'd1);
    axi.S_AXI_WDATA = 32'h000000AA;
    axi.S_AXI_WSTRB = 4'h1;
    axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_WVALID = 1'b0;
    chk("w_rdy_held", {31'd0, axi.S_AXI_WREADY}, 32'd0);
    repeat (2) @(negedge clk);
    chk("no_early_b", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    axi.S_AXI_AWADDR = 4'h4;
    axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
      chk("bp_bresp", {30'd0, axi.S_AXI_BRESP}, 32'd0);
      chk("bp_readies", {30'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 32'd0);
      @(negedge clk);
    end
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    chk("b_released", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    @(negedge clk);
    chk("rdy_back", {30'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 32'd3);
    axi_read(4'h4, rd); chk("skew_arg", rd, 32'hDEAD12AA);

    // RESULT is read-only.
    axi_write(4'h8, 32'h12345678, 4'hF, resp);
    chk("result_slverr", {30'd0, resp}, 32'd2);
    axi_read(4'h8, rd); chk("result_kept", rd, 32'h40000000);

    // Collision: W1C of done in the same cycle as core_done, set wins.
    core_result = 32'h40490FDB;
    core_done = 1'b1;
    fork
      begin
        @(negedge clk);
        core_done = 1'b0;
      end
    join_none
    axi_write(4'hC, 32'h2, 4'hF, resp);
    axi_read(4'hC, rd); chk("collide_done", rd, 32'h2);
    axi_write(4'hC, 32'h2, 4'hF, resp);
    axi_read(4'hC, rd); chk("w1c_again", rd, 32'h0);

    // STATUS read alongside core_done sees the pre-update value.
    core_done = 1'b1;
    fork
      begin
        @(negedge clk);
        core_done = 1'b0;
      end
    join_none
    axi_read(4'hC, rd); chk("rd_pre_update", rd, 32'h0);
    axi_read(4'hC, rd); chk("rd_post_update", rd, 32'h2);

    // R held off for 5 cycles: data stable, no new AR accepted.
    axi.S_AXI_ARADDR = 4'h8;
    axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rbp_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd1);
      chk("rbp_rdata", axi.S_AXI_RDATA, 32'h40490FDB);
      chk("rbp_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd0);
      @(negedge clk);
    end
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    chk("r_released", {31'd0, axi.S_AXI_RVALID}, 32'd0);
    @(negedge clk);
    chk("arready_back", {31'd0, axi.S_AXI_ARREADY}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
